// File: rtl/prl_tx_pkg.sv
// Shared types and defaults for the protocol-layer TX state machine.
package prl_tx_pkg;

  typedef enum logic [1:0] {
    RESULT_SUCCESS   = 2'd0,
    RESULT_FAIL      = 2'd1,
    RESULT_DISCARDED = 2'd2
  } result_e;

  typedef enum logic [2:0] {
    SOP         = 3'd0,
    SOP_P       = 3'd1,
    SOP_PP      = 3'd2,
    HARD_RESET  = 3'd3,
    CABLE_RESET = 3'd4
  } sop_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_PHY,
    ST_WAIT_CRC,
    ST_ACK
  } state_e;

  localparam int          N_RETRY_DEF     = 2;
  localparam logic [15:0] CRC_TIMEOUT_DEF = 16'd10800;

  // Only SOP/SOP'/SOP'' carry a MessageID and expect a GoodCRC.
  function automatic logic is_msg_sop(input logic [2:0] s);
    return s <= SOP_PP;
  endfunction

endpackage

// File: rtl/prl_tx_crc_timer.sv
// tCRCReceive counter: clears on request, counts while enabled and flags the
// final cycle of the window.
module prl_tx_crc_timer #(
  parameter int             W       = 16,
  parameter logic [W-1:0]   TIMEOUT = W'(10800)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] TC_VAL = TIMEOUT - W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = en && !clear && (count == TC_VAL);

endmodule

// File: rtl/prl_tx_st.sv
// Protocol-layer TX state machine: PHY strobe, GoodCRC wait, retries,
// per-SOP MessageID counters and the upstream completion handshake.
module prl_tx_st
  import prl_tx_pkg::*;
#(
  parameter int          N_RETRY     = N_RETRY_DEF,
  parameter logic [15:0] CRC_TIMEOUT = CRC_TIMEOUT_DEF,
  parameter int          CRC_TIMER_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       prl_tx_if_en,
  input  logic [2:0] prl_tx_if_sop_type,
  input  logic [1:0] prl_tx_if_message_type,
  input  logic [4:0] prl_tx_if_header_type,
  output logic       prl_tx_st_message_if_ack,
  output logic [1:0] prl_tx_st_message_if_ack_result,
  output logic       prl_tx_phy_start,
  output logic [2:0] prl_tx_phy_sop_type,
  output logic [2:0] prl_tx_phy_message_id,
  output logic       prl_tx_phy_retry,
  input  logic       phy_tx_done,
  input  logic       phy_tx_fail,
  input  logic       prl_rx_goodcrc_vld,
  input  logic [2:0] prl_rx_goodcrc_sop_type,
  input  logic [2:0] prl_rx_goodcrc_message_id,
  input  logic       prl_rx_message_vld,
  input  logic       pl_hard_reset
);

  localparam int RETRY_W = (N_RETRY < 1) ? 1 : $clog2(N_RETRY + 1);

  state_e             state;
  logic [2:0]         sop_q;
  logic [RETRY_W-1:0] retry_cnt;
  logic [2:0]         msg_id [3];
  logic [2:0]         cur_id;
  logic               busy;
  logic               crc_match;
  logic               can_retry;
  logic               timer_clear;
  logic               timer_en;
  logic               timer_tc;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur_id = '0;
    for (int i = 0; i < 3; i++) begin
      if (sop_q == 3'(i)) cur_id = msg_id[i];
    end
  end

  assign busy      = state inside {ST_START, ST_WAIT_PHY, ST_WAIT_CRC};
  assign crc_match = prl_rx_goodcrc_vld &&
                     (prl_rx_goodcrc_sop_type == sop_q) &&
                     (prl_rx_goodcrc_message_id == cur_id);
  assign can_retry = retry_cnt < RETRY_W'(N_RETRY);

  // The timer is held at zero outside WAIT_CRC, so each wait starts fresh.
  assign timer_en    = (state == ST_WAIT_CRC);
  assign timer_clear = pl_hard_reset || (state != ST_WAIT_CRC);

  prl_tx_crc_timer #(
    .W       (CRC_TIMER_W),
    .TIMEOUT (CRC_TIMER_W'(CRC_TIMEOUT))
  ) u_crc_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clear),
    .en    (timer_en),
    .tc    (timer_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                           <= ST_IDLE;
      sop_q                           <= '0;
      retry_cnt                       <= '0;
      // NOTE: the MessageID array is protocol state, so it is reset like any register.
      for (int i = 0; i < 3; i++) msg_id[i] <= '0;
      prl_tx_st_message_if_ack        <= 1'b0;
      prl_tx_st_message_if_ack_result <= '0;
      prl_tx_phy_start                <= 1'b0;
      prl_tx_phy_sop_type             <= '0;
      prl_tx_phy_message_id           <= '0;
      prl_tx_phy_retry                <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; these defaults make the strobes one cycle wide.
      prl_tx_phy_start         <= 1'b0;
      prl_tx_st_message_if_ack <= 1'b0;

      if (pl_hard_reset) begin
        retry_cnt <= '0;
        for (int i = 0; i < 3; i++) msg_id[i] <= '0;
        if (busy) begin
          state                           <= ST_ACK;
          prl_tx_st_message_if_ack        <= 1'b1;
          prl_tx_st_message_if_ack_result <= RESULT_DISCARDED;
        end else begin
          state <= ST_IDLE;
        end
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (prl_tx_if_en) begin
              sop_q <= prl_tx_if_sop_type;
              state <= ST_START;
            end
          end

          ST_START: begin
            if (prl_rx_message_vld) begin
              state                           <= ST_ACK;
              prl_tx_st_message_if_ack        <= 1'b1;
              prl_tx_st_message_if_ack_result <= RESULT_DISCARDED;
            end else begin
              prl_tx_phy_start      <= 1'b1;
              prl_tx_phy_sop_type   <= sop_q;
              prl_tx_phy_message_id <= cur_id;
              prl_tx_phy_retry      <= (retry_cnt != '0);
              state                 <= ST_WAIT_PHY;
            end
          end

          ST_WAIT_PHY: begin
            if (prl_rx_message_vld) begin
              state                           <= ST_ACK;
              prl_tx_st_message_if_ack        <= 1'b1;
              prl_tx_st_message_if_ack_result <= RESULT_DISCARDED;
            end else if (phy_tx_fail) begin
              if (can_retry) begin
                retry_cnt <= retry_cnt + RETRY_W'(1);
                state     <= ST_START;
              end else begin
                state                           <= ST_ACK;
                prl_tx_st_message_if_ack        <= 1'b1;
                prl_tx_st_message_if_ack_result <= RESULT_FAIL;
              end
            end else if (phy_tx_done) begin
              if (is_msg_sop(sop_q)) begin
                state <= ST_WAIT_CRC;
              end else begin
                state                           <= ST_ACK;
                prl_tx_st_message_if_ack        <= 1'b1;
                prl_tx_st_message_if_ack_result <= RESULT_SUCCESS;
              end
            end
          end

          ST_WAIT_CRC: begin
            if (crc_match) begin
              state                           <= ST_ACK;
              prl_tx_st_message_if_ack        <= 1'b1;
              prl_tx_st_message_if_ack_result <= RESULT_SUCCESS;
            end else if (prl_rx_message_vld) begin
              state                           <= ST_ACK;
              prl_tx_st_message_if_ack        <= 1'b1;
              prl_tx_st_message_if_ack_result <= RESULT_DISCARDED;
            end else if (timer_tc) begin
              if (can_retry) begin
                retry_cnt <= retry_cnt + RETRY_W'(1);
                state     <= ST_START;
              end else begin
                state                           <= ST_ACK;
                prl_tx_st_message_if_ack        <= 1'b1;
                prl_tx_st_message_if_ack_result <= RESULT_FAIL;
              end
            end
          end

          ST_ACK: begin
            retry_cnt <= '0;
            // A discarded message never consumed its MessageID.
            if (prl_tx_st_message_if_ack_result != RESULT_DISCARDED) begin
              for (int i = 0; i < 3; i++) begin
                if (sop_q == 3'(i)) msg_id[i] <= msg_id[i] + 3'd1;
              end
            end
            state <= ST_IDLE;
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
